// File: rtl/apu_pkg.sv
// Shared APU constants: frame-sequencer step cycles, mode encoding, $4017 layout.
package apu_pkg;

   // Default CPU-cycle counts at which each frame-sequencer step fires
   localparam int Q1_CYCLE_DEF    = 7457;
   localparam int Q2_CYCLE_DEF    = 14913;
   localparam int Q3_CYCLE_DEF    = 22371;
   localparam int Q4_CYCLE_DEF    = 29829;
   localparam int Q5_CYCLE_DEF    = 37281;
   localparam int WRITE_DELAY_DEF = 3;

   // Sequencer mode encoding
   localparam logic MODE_4STEP = 1'b0;
   localparam logic MODE_5STEP = 1'b1;

   // $4017 bit positions
   localparam int R4017_MODE_BIT = 7;
   localparam int R4017_INH_BIT  = 6;

   // Pending-write tracker states
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } wr_state_e;

endpackage

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: counts CPU cycles, emits quarter/half-frame strobes,
// owns the frame IRQ and applies $4017 writes after a short delay.
module apu_frame_sequencer
   import apu_pkg::*;
#(
   parameter int Q1_CYCLE    = Q1_CYCLE_DEF,
   parameter int Q2_CYCLE    = Q2_CYCLE_DEF,
   parameter int Q3_CYCLE    = Q3_CYCLE_DEF,
   parameter int Q4_CYCLE    = Q4_CYCLE_DEF,
   parameter int Q5_CYCLE    = Q5_CYCLE_DEF,
   parameter int WRITE_DELAY = WRITE_DELAY_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iCpu_ce,
   input  logic       iWrite,
   input  logic [7:0] iData,
   input  logic       iStatus_read,
   output logic       oQuarter_clk,
   output logic       oHalf_clk,
   output logic       oIrq,
   output logic       oMode
);

   localparam logic [15:0] Q1   = 16'(Q1_CYCLE);
   localparam logic [15:0] Q2   = 16'(Q2_CYCLE);
   localparam logic [15:0] Q3   = 16'(Q3_CYCLE);
   localparam logic [15:0] Q4   = 16'(Q4_CYCLE);
   localparam logic [15:0] Q4M1 = 16'(Q4_CYCLE - 1);
   localparam logic [15:0] Q5   = 16'(Q5_CYCLE);
   localparam logic [1:0]  DLY  = 2'(WRITE_DELAY);

   logic [15:0] cnt;
   logic        mode, inhibit, irq, wrapped;
   logic        quarter_q, half_q;

   wr_state_e   state, state_nxt;
   logic [1:0]  dly, dly_nxt;
   logic        lat_mode, lat_mode_nxt, lat_inh, lat_inh_nxt;
   logic        apply;

   logic [15:0] last_step;
   logic        at_last, hit_q, hit_h, irq_set, wr_inh;

   // Only bits 7:6 of $4017 matter here
   logic unused_data;
   assign unused_data = ^iData[5:0];

   // Pending-write registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         dly      <= '0;
         lat_mode <= MODE_4STEP;
         lat_inh  <= 1'b0;
      end else begin
         state    <= state_nxt;
         dly      <= dly_nxt;
         lat_mode <= lat_mode_nxt;
         lat_inh  <= lat_inh_nxt;
      end
   end

   // Pending-write next state: a new write always (re)starts the delay,
   // so a write landing on the would-be apply cycle postpones the apply
   always_comb begin
      state_nxt    = state;
      dly_nxt      = dly;
      lat_mode_nxt = lat_mode;
      lat_inh_nxt  = lat_inh;
      apply        = 1'b0;
      if (iCpu_ce) begin
         if (iWrite) begin
            lat_mode_nxt = iData[R4017_MODE_BIT];
            lat_inh_nxt  = iData[R4017_INH_BIT];
            state_nxt    = ST_PENDING;
            dly_nxt      = DLY;
         end else if (state == ST_PENDING) begin
            if (dly == 2'd1) begin
               apply     = 1'b1;
               state_nxt = ST_IDLE;
               dly_nxt   = '0;
            end else begin
               dly_nxt   = dly - 2'd1;
            end
         end
      end
   end

   // Step decode on the current count under the current mode
   always_comb begin
      last_step = (mode == MODE_5STEP) ? Q5 : Q4;
      at_last   = (cnt == last_step);
      hit_q     = (cnt == Q1) || (cnt == Q2) || (cnt == Q3) || at_last;
      hit_h     = (cnt == Q2) || at_last;
      irq_set   = (mode == MODE_4STEP) && !inhibit &&
                  ((cnt == Q4M1) || (cnt == Q4) || ((cnt == 16'd0) && wrapped));
      wr_inh    = iWrite && iData[R4017_INH_BIT];
   end

   // Counter, strobes, mode and IRQ; strobes default low so they stay one clk wide
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         mode      <= MODE_4STEP;
         inhibit   <= 1'b0;
         wrapped   <= 1'b0;
         irq       <= 1'b0;
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
      end else begin
         quarter_q <= 1'b0;
         half_q    <= 1'b0;
         if (iCpu_ce) begin
            if (apply) begin
               // Apply suppresses any step strobe; only 5-step mode pulses here
               cnt       <= '0;
               wrapped   <= 1'b0;
               mode      <= lat_mode;
               inhibit   <= lat_inh;
               quarter_q <= (lat_mode == MODE_5STEP);
               half_q    <= (lat_mode == MODE_5STEP);
            end else begin
               quarter_q <= hit_q;
               half_q    <= hit_h;
               wrapped   <= at_last && (mode == MODE_4STEP);
               cnt       <= at_last ? 16'd0 : cnt + 16'd1;
            end
            // Inhibit write beats set; set beats status read
            if (wr_inh)
               irq <= 1'b0;
            else if (irq_set)
               irq <= 1'b1;
            else if (iStatus_read)
               irq <= 1'b0;
         end
      end
   end

   assign oQuarter_clk = quarter_q;
   assign oHalf_clk    = half_q;
   assign oIrq         = irq;
   assign oMode        = mode;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer, using shortened step cycles so
// several full periods fit in a short run.
module tb_apu_frame_sequencer;

   localparam int Q1 = 20, Q2 = 41, Q3 = 61, Q4 = 82, Q5 = 102, WD = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1, iCpu_ce = 1'b0, iWrite = 1'b0, iStatus_read = 1'b0;
   logic [7:0] iData = 8'h00;
   logic       oQuarter_clk, oHalf_clk, oIrq, oMode;

   apu_frame_sequencer #(
      .Q1_CYCLE(Q1), .Q2_CYCLE(Q2), .Q3_CYCLE(Q3), .Q4_CYCLE(Q4),
      .Q5_CYCLE(Q5), .WRITE_DELAY(WD)
   ) dut (
      .clk(clk), .reset(reset), .iCpu_ce(iCpu_ce), .iWrite(iWrite),
      .iData(iData), .iStatus_read(iStatus_read),
      .oQuarter_clk(oQuarter_clk), .oHalf_clk(oHalf_clk),
      .oIrq(oIrq), .oMode(oMode)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic q, h, irq, mode;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Reference model: position within the frame, current mode, and a
   // countdown for the pending write (0 = nothing pending)
   int   m_pos = 0, m_left = 0;
   bit   m_mode = 0, m_inh = 0, m_irq = 0, m_just_wrapped = 0;
   bit   m_lat_mode = 0, m_lat_inh = 0;

   task automatic model(input bit rst, input bit ce, input bit wr,
                        input logic [7:0] d, input bit rd, output exp_t e);
      int  period_end;
      bit  q, h, set_irq;
      e = '0;
      if (rst) begin
         m_pos = 0; m_left = 0; m_mode = 0; m_inh = 0; m_irq = 0;
         m_just_wrapped = 0; m_lat_mode = 0; m_lat_inh = 0;
      end else if (ce) begin
         period_end = m_mode ? Q5 : Q4;
         set_irq = !m_mode && !m_inh &&
                   (m_pos == Q4 - 1 || m_pos == Q4 || (m_pos == 0 && m_just_wrapped));
         if (m_left == 1 && !wr) begin
            q = m_lat_mode; h = m_lat_mode;
            m_pos = 0; m_just_wrapped = 0;
            m_mode = m_lat_mode; m_inh = m_lat_inh; m_left = 0;
         end else begin
            q = (m_pos == Q1) || (m_pos == Q2) || (m_pos == Q3) || (m_pos == period_end);
            h = (m_pos == Q2) || (m_pos == period_end);
            m_just_wrapped = (m_pos == period_end) && !m_mode;
            m_pos = (m_pos + 1) % (period_end + 1);
            if (wr) begin
               m_lat_mode = d[7]; m_lat_inh = d[6]; m_left = WD;
            end else if (m_left > 0) begin
               m_left--;
            end
         end
         if (wr && d[6]) m_irq = 0;
         else if (set_irq) m_irq = 1;
         else if (rd) m_irq = 0;
         e.q = q; e.h = h;
      end
      e.irq  = m_irq;
      e.mode = m_mode;
   endtask

   // Drive one clk worth of inputs and queue the response expected after the edge
   task automatic drive(input bit rst, input bit ce, input bit wr,
                        input logic [7:0] d, input bit rd);
      exp_t e;
      @(negedge clk);
      reset = rst; iCpu_ce = ce; iWrite = wr; iData = d; iStatus_read = rd;
      model(rst, ce, wr, d, rd, e);
      sb.push_back(e);
   endtask

   // Monitor: one expected entry per clk once stimulus has started
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({oQuarter_clk, oHalf_clk, oIrq, oMode} === e)
               n_pass++;
            else
               $display("FAIL outputs cyc=%0d got q=%b h=%b irq=%b mode=%b want q=%b h=%b irq=%b mode=%b",
                        cyc, oQuarter_clk, oHalf_clk, oIrq, oMode, e.q, e.h, e.irq, e.mode);
         end
      end
   end

   initial begin
      int per4;
      per4 = Q4 + 1;

      // Reset
      repeat (3) drive(1, 0, 0, 8'h00, 0);

      // 4-step periods; read at Q4 (set wins) in period 2, at count 10 in period 3
      for (int i = 0; i < 3 * per4 + 5; i++)
         drive(0, 1, 0, 8'h00,
               (i > per4 && i < 2 * per4 && m_pos == Q4) || (i > 2 * per4 && m_pos == 10));

      // Let IRQ come back, then inhibit write clears it immediately
      for (int i = 0; i < per4; i++) drive(0, 1, 0, 8'h00, 0);
      drive(0, 1, 1, 8'h40, 0);
      for (int i = 0; i < per4 + 20; i++) drive(0, 1, 0, 8'h00, 0);

      // 5-step mode with inhibit
      drive(0, 1, 1, 8'hC0, 0);
      for (int i = 0; i < 3 * (Q5 + 1); i++) drive(0, 1, 0, 8'h00, 0);

      // Rewrite during delay
      drive(0, 1, 1, 8'h80, 0);
      drive(0, 1, 1, 8'h00, 0);
      for (int i = 0; i < 20; i++) drive(0, 1, 0, 8'h00, 0);

      // Reset mid-pending
      drive(0, 1, 1, 8'h80, 0);
      drive(1, 1, 0, 8'h00, 0);
      for (int i = 0; i < 10; i++) drive(0, 1, 0, 8'h00, 0);

      // Randomized traffic with gaps in iCpu_ce
      for (int i = 0; i < 4000; i++)
         drive(($urandom % 1500) == 0, ($urandom % 4) != 0, ($urandom % 60) == 0,
               8'($urandom), ($urandom % 40) == 0);

      drive(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain left=%0d want 0", sb.size());
      end
      if (n_checks < 12) begin
         n_checks++;
         $display("FAIL check_count got=%0d want >=12", n_checks);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
